rc4_stream_xor: RTL and testbench

- Consumer end of the RC4 keystream interface. It pulls keystream bytes from the keystream generator using the key_valid / nxt_key handshake and buffers them in a small prefetch FIFO.
- It XORs each buffered byte with incoming plaintext bytes and emits ciphertext on a valid/ready stream.
- Optionally discards the first DROP_N keystream bytes (RC4-drop[N]).
- Sits between the keystream generator and the system data path. Because RC4 is symmetric, the same block performs decryption.

---
 rtl/rc4_stream_xor.sv | 129 ++++++++++++
 tb/tb_rc4_stream_xor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_xor.sv
// Keystream consumer for an RC4 generator: prefetches keystream bytes into a small FIFO,
// optionally discards the first DROP_N bytes, and XORs plaintext into a registered ct stream.
module rc4_stream_xor #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_N     = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [7:0]       key_in,
  output logic             nxt_key,
  input  logic             pt_valid,
  input  logic [7:0]       pt_data,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic [7:0]       ct_data,
  input  logic             ct_ready,
  output logic             drop_done,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);
  localparam logic [16:0] DropC  = 17'(DROP_N);

  typedef enum logic [0:0] {StDrop, StRun} state_e;

  state_e             st_q, st_d;
  logic               nxt_key_q, nxt_key_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ct_valid_q, ct_valid_d;
  logic [7:0]         ct_data_q, ct_data_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

  logic capture, push, pop;

  // Occupancy is judged on the registered count, so a same-cycle pop never frees a slot.
  assign capture = key_valid & ~nxt_key_q & ((st_q == StDrop) | (count_q < DepthC));
  assign push    = capture & (st_q == StRun);
  assign pt_ready = (st_q == StRun) & (count_q != '0) & (~ct_valid_q | ct_ready);
  assign pop     = pt_valid & pt_ready;

  always_comb begin
    st_d       = st_q;
    nxt_key_d  = capture;
    drop_cnt_d = drop_cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    byte_cnt_d = byte_cnt_q;

    if (capture && (st_q == StDrop)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
      if (({1'b0, drop_cnt_q} + 17'd1) == DropC) begin
        st_d = StRun;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = key_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      ct_valid_d = 1'b1;
      ct_data_d  = pt_data ^ mem_q[rd_ptr_q];
    end else if (ct_ready) begin
      ct_valid_d = 1'b0;
    end

    if (ct_valid_q && ct_ready) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= (DROP_N > 0) ? StDrop : StRun;
      nxt_key_q  <= 1'b0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      nxt_key_q  <= nxt_key_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign nxt_key   = nxt_key_q;
  assign ct_valid  = ct_valid_q;
  assign ct_data   = ct_data_q;
  assign byte_cnt  = byte_cnt_q;
  assign drop_done = (st_q == StRun);

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: two instances (DROP_N=0 and DROP_N=2) fed by an RC4("Key")
// generator model; a negedge monitor checks every cycle against counts-based expectations.
module tb_rc4_stream_xor;

  localparam int Depth = 4;

  typedef struct packed {
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [1:0]       key_valid;
  logic [1:0][7:0]  key_in;
  logic [1:0]       nxt_key;
  logic [1:0]       pt_valid;
  logic [1:0][7:0]  pt_data;
  logic [1:0]       pt_ready;
  logic [1:0]       ct_valid;
  logic [1:0][7:0]  ct_data;
  logic [1:0]       ct_ready;
  logic [1:0]       drop_done;
  logic [1:0][15:0] byte_cnt;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] ks [4096];
  int         gen_idx [2];
  int         nk_cnt [2];
  int         acc_n [2];
  int         out_n [2];
  logic       prev_nk [2];
  logic       held [2];
  logic [7:0] held_data [2];
  logic [7:0] pt_hist [2][4096];
  vec_t       vec [9];

  rc4_stream_xor #(.FIFO_DEPTH(Depth), .DROP_N(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_in(key_in[0]), .nxt_key(nxt_key[0]),
    .pt_valid(pt_valid[0]), .pt_data(pt_data[0]), .pt_ready(pt_ready[0]),
    .ct_valid(ct_valid[0]), .ct_data(ct_data[0]), .ct_ready(ct_ready[0]),
    .drop_done(drop_done[0]), .byte_cnt(byte_cnt[0])
  );

  rc4_stream_xor #(.FIFO_DEPTH(Depth), .DROP_N(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_in(key_in[1]), .nxt_key(nxt_key[1]),
    .pt_valid(pt_valid[1]), .pt_data(pt_data[1]), .pt_ready(pt_ready[1]),
    .ct_valid(ct_valid[1]), .ct_data(ct_data[1]), .ct_ready(ct_ready[1]),
    .drop_done(drop_done[1]), .byte_cnt(byte_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int drop_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL d%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", d, name, act, exp, $time);
    end
  endtask

  // Generator model: presents ks[idx], advances when it sees the nxt_key pulse.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        gen_idx[d] <= 0;
        key_in[d]  <= ks[0];
      end else if (nxt_key[d]) begin
        gen_idx[d] <= gen_idx[d] + 1;
        key_in[d]  <= ks[gen_idx[d] + 1];
      end
    end
  end

  // Monitor: handshakes are judged at negedge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nk_cnt[d]  = 0;
        acc_n[d]   = 0;
        out_n[d]   = 0;
        prev_nk[d] = 1'b0;
        held[d]    = 1'b0;
      end else begin
        int fill;
        logic exp_rdy;
        chk(d, "byte_cnt", 32'(byte_cnt[d]), 32'(out_n[d] % 65536));
        chk(d, "ct_valid", 32'(ct_valid[d]), 32'(acc_n[d] != out_n[d]));
        if (held[d]) chk(d, "ct_hold", 32'(ct_data[d]), 32'(held_data[d]));
        if (nxt_key[d]) begin
          chk(d, "nxt_key_b2b", 32'(prev_nk[d]), 32'd0);
          nk_cnt[d]++;
        end
        chk(d, "drop_done", 32'(drop_done[d]), 32'(nk_cnt[d] >= drop_of(d)));
        fill = nk_cnt[d] - drop_of(d) - acc_n[d];
        chk(d, "fifo_bound", 32'(fill <= Depth), 32'd1);
        exp_rdy = (nk_cnt[d] >= drop_of(d)) && (fill > 0) && (!ct_valid[d] || ct_ready[d]);
        chk(d, "pt_ready", 32'(pt_ready[d]), 32'(exp_rdy));
        if (ct_valid[d] && ct_ready[d]) begin
          chk(d, "ct_data", 32'(ct_data[d]),
              32'(pt_hist[d][out_n[d]] ^ ks[drop_of(d) + out_n[d]]));
          out_n[d]++;
        end
        held[d]      = ct_valid[d] && !ct_ready[d];
        held_data[d] = ct_data[d];
        if (pt_valid[d] && pt_ready[d]) begin
          pt_hist[d][acc_n[d]] = pt_data[d];
          acc_n[d]++;
        end
        prev_nk[d] = nxt_key[d];
      end
    end
  end

  // Offer one byte, wait (bounded) for acceptance; returns 1 time unit after the accepting edge.
  task automatic send(input int d, input logic [7:0] b);
    int t;
    t = 0;
    pt_valid[d] = 1'b1;
    pt_data[d]  = b;
    @(negedge clk);
    while (!pt_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!pt_ready[d]) chk(d, "send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    pt_valid[d] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s [256];
    logic [7:0] key [3];
    logic [7:0] a, b, t;
    logic [7:0] hold_v;
    logic [15:0] bc0;
    int idx;

    rst = 1'b1; key_valid = '0; pt_valid = '0; pt_data = '0; ct_ready = '1;

    key = '{8'h4B, 8'h65, 8'h79};
    for (int i = 0; i < 256; i++) s[i] = 8'(i);
    b = 8'd0;
    for (int i = 0; i < 256; i++) begin
      b = b + s[i] + key[i % 3];
      t = s[i]; s[i] = s[b]; s[b] = t;
    end
    a = 8'd0; b = 8'd0;
    for (int n = 0; n < 4096; n++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      t = s[a] + s[b];
      ks[n] = s[t];
    end

    vec[0] = '{8'h50, 8'hBB}; vec[1] = '{8'h6C, 8'hF3}; vec[2] = '{8'h61, 8'h16};
    vec[3] = '{8'h69, 8'hE8}; vec[4] = '{8'h6E, 8'hD9}; vec[5] = '{8'h74, 8'h40};
    vec[6] = '{8'h65, 8'hAF}; vec[7] = '{8'h78, 8'h0A}; vec[8] = '{8'h74, 8'hD3};

    cycles(3);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_nxt_key", 32'(nxt_key[d]), 32'd0);
      chk(d, "rst_pt_ready", 32'(pt_ready[d]), 32'd0);
      chk(d, "rst_ct_valid", 32'(ct_valid[d]), 32'd0);
      chk(d, "rst_ct_data", 32'(ct_data[d]), 32'd0);
      chk(d, "rst_byte_cnt", 32'(byte_cnt[d]), 32'd0);
      chk(d, "rst_drop_done", 32'(drop_done[d]), 32'(d == 0));
    end

    // Prefetch with no plaintext: fill the FIFO (plus drops on instance 1), then idle.
    cycles(5);
    chk(0, "no_pull_without_key_valid", 32'(nk_cnt[0]), 32'd0);
    key_valid = '1;
    cycles(40);
    chk(0, "prefetch_pulses", 32'(nk_cnt[0]), 32'(Depth));
    chk(1, "drop_prefetch_pulses", 32'(nk_cnt[1]), 32'(2 + Depth));
    chk(1, "drop_done_after_drop", 32'(drop_done[1]), 32'd1);

    // "Plaintext" under RC4 key "Key".
    for (int i = 0; i < 9; i++) begin
      send(0, vec[i].pt);
      chk(0, "vec_ct_valid", 32'(ct_valid[0]), 32'd1);
      chk(0, "vec_ct_data", 32'(ct_data[0]), 32'(vec[i].ct));
    end
    cycles(1);
    chk(0, "vec_byte_cnt", 32'(byte_cnt[0]), 32'd9);

    send(1, 8'h00);
    chk(1, "drop_ct0", 32'(ct_data[1]), 32'h77);
    send(1, 8'h00);
    chk(1, "drop_ct1", 32'(ct_data[1]), 32'h81);

    // Backpressure.
    cycles(1);
    ct_ready[0] = 1'b0;
    idx = acc_n[0];
    send(0, 8'h3C);
    hold_v = 8'h3C ^ ks[idx];
    chk(0, "bp_first", 32'(ct_data[0]), 32'(hold_v));
    bc0 = byte_cnt[0];
    pt_valid[0] = 1'b1;
    pt_data[0]  = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk(0, "bp_valid", 32'(ct_valid[0]), 32'd1);
      chk(0, "bp_data", 32'(ct_data[0]), 32'(hold_v));
      chk(0, "bp_pt_ready", 32'(pt_ready[0]), 32'd0);
      chk(0, "bp_byte_cnt", 32'(byte_cnt[0]), 32'(bc0));
    end
    pt_valid[0] = 1'b0;
    ct_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idx = acc_n[0];
      send(0, 8'(8'h10 + i));
      chk(0, "bp_resume", 32'(ct_data[0]), 32'((8'h10 + 8'(i)) ^ ks[idx]));
    end

    // Generator stall with the FIFO drained.
    key_valid[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pt_valid[0] = 1'b1;
      pt_data[0]  = 8'($urandom);
      cycles(1);
    end
    for (int i = 0; i < 10; i++) begin
      chk(0, "stall_pt_ready", 32'(pt_ready[0]), 32'd0);
      cycles(1);
    end
    pt_valid[0] = 1'b0;
    key_valid[0] = 1'b1;
    idx = acc_n[0];
    send(0, 8'h99);
    chk(0, "stall_resume", 32'(ct_data[0]), 32'(8'h99 ^ ks[idx]));

    // Randomized traffic on both instances; the monitor does the checking.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        pt_valid[d]  = 1'($urandom_range(0, 1));
        pt_data[d]   = 8'($urandom);
        ct_ready[d]  = ($urandom_range(0, 3) != 0);
        key_valid[d] = ($urandom_range(0, 3) != 0);
      end
      cycles(1);
    end

    // Reset mid-stream after three outputs with the FIFO partly full.
    pt_valid = '0; ct_ready = '1; key_valid = '1;
    cycles(10);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) send(d, 8'($urandom));
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "mid_rst_ct_valid", 32'(ct_valid[d]), 32'd0);
      chk(d, "mid_rst_byte_cnt", 32'(byte_cnt[d]), 32'd0);
      chk(d, "mid_rst_pt_ready", 32'(pt_ready[d]), 32'd0);
      chk(d, "mid_rst_drop_done", 32'(drop_done[d]), 32'(d == 0));
    end
    send(0, 8'h5A);
    chk(0, "fresh_stream", 32'(ct_data[0]), 32'(8'h5A ^ ks[0]));
    send(1, 8'hA5);
    chk(1, "fresh_stream_drop", 32'(ct_data[1]), 32'(8'hA5 ^ ks[2]));
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
